// File: rtl/fp_pkg.sv
// rtl/fp_pkg.sv - shared binary32 field widths, constants and converter FSM states
package fp_pkg;

    localparam int EXP_W    = 8;
    localparam int MAN_W    = 23;
    localparam int EXP_BIAS = 127;

    localparam logic [31:0] FP32_ZERO = 32'h0000_0000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        NORM  = 2'd1,
        ROUND = 2'd2,
        DONE  = 2'd3
    } conv_state_e;

endpackage

// File: rtl/fp_round_rne.sv
// rtl/fp_round_rne.sv - combinational round-to-nearest-even of a normalised binary32 mantissa
module fp_round_rne
    import fp_pkg::*;
(
    input  logic [MAN_W-1:0] man_i,
    input  logic             guard_i,
    input  logic             sticky_i,
    input  logic [EXP_W-1:0] exp_i,
    output logic [MAN_W-1:0] man_o,
    output logic [EXP_W-1:0] exp_o,
    output logic             inexact_o
);

    logic           round_up;
    logic [MAN_W:0] man_inc;

    // Round up above half, or at exactly half when the kept lsb is odd; a
    // carry out of the mantissa renormalises into the exponent.
    always_comb begin
        round_up  = guard_i & (sticky_i | man_i[0]);
        man_inc   = {1'b0, man_i} + {{MAN_W{1'b0}}, round_up};
        inexact_o = guard_i | sticky_i;
        man_o     = man_inc[MAN_W-1:0];
        exp_o     = exp_i;
        if (man_inc[MAN_W]) begin
            man_o = '0;
            exp_o = exp_i + 8'd1;
        end
    end

endmodule

// File: rtl/int_to_fp32_converter.sv
// rtl/int_to_fp32_converter.sv - iterative 32-bit integer to binary32 converter with RNE rounding
module int_to_fp32_converter #(
    parameter int XLEN     = 32,
    parameter int EXP_BIAS = 127
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] in_data,
    input  logic            in_signed,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [31:0]     out_data,
    output logic            out_inexact
);

    import fp_pkg::*;

    conv_state_e      state_q, state_d;
    logic [31:0]      mag_q, mag_d;
    logic [4:0]       cnt_q, cnt_d;
    logic             sign_q, sign_d;
    logic [31:0]      out_data_q, out_data_d;
    logic             out_inexact_q, out_inexact_d;

    logic             in_neg;
    logic [31:0]      in_mag;
    logic [EXP_W-1:0] exp_pre;
    logic [MAN_W-1:0] rnd_man;
    logic [EXP_W-1:0] rnd_exp;
    logic             rnd_inexact;

    // Magnitude of the incoming operand; the most negative value maps onto itself.
    always_comb begin
        in_neg = in_signed & in_data[XLEN-1];
        in_mag = in_neg ? (~in_data + 32'd1) : in_data;
    end

    // Exponent before rounding: msb position 31 minus the shifts already taken.
    always_comb begin
        exp_pre = 8'(EXP_BIAS + 31) - {3'b000, cnt_q};
    end

    fp_round_rne u_round (
        .man_i     (mag_q[30:8]),
        .guard_i   (mag_q[7]),
        .sticky_i  (|mag_q[6:0]),
        .exp_i     (exp_pre),
        .man_o     (rnd_man),
        .exp_o     (rnd_exp),
        .inexact_o (rnd_inexact)
    );

    // Next-state logic: accept, normalise one bit per cycle, round, hold result.
    always_comb begin
        state_d       = state_q;
        mag_d         = mag_q;
        cnt_d         = cnt_q;
        sign_d        = sign_q;
        out_data_d    = out_data_q;
        out_inexact_d = out_inexact_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    sign_d = in_neg;
                    mag_d  = in_mag;
                    cnt_d  = '0;
                    if (in_mag == 32'd0) begin
                        out_data_d    = FP32_ZERO;
                        out_inexact_d = 1'b0;
                        state_d       = DONE;
                    end else begin
                        state_d = NORM;
                    end
                end
            end
            NORM: begin
                if (mag_q[31]) begin
                    state_d = ROUND;
                end else begin
                    mag_d = mag_q << 1;
                    cnt_d = cnt_q + 5'd1;
                end
            end
            ROUND: begin
                out_data_d    = {sign_q, rnd_exp, rnd_man};
                out_inexact_d = rnd_inexact;
                state_d       = DONE;
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset drops any conversion in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            mag_q         <= '0;
            cnt_q         <= '0;
            sign_q        <= 1'b0;
            out_data_q    <= '0;
            out_inexact_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            mag_q         <= mag_d;
            cnt_q         <= cnt_d;
            sign_q        <= sign_d;
            out_data_q    <= out_data_d;
            out_inexact_q <= out_inexact_d;
        end
    end

    // Handshake outputs decode the registered state only.
    always_comb begin
        in_ready    = (state_q == IDLE);
        out_valid   = (state_q == DONE);
        out_data    = out_data_q;
        out_inexact = out_inexact_q;
    end

endmodule

// File: tb/tb_int_to_fp32_converter.sv
// tb/tb_int_to_fp32_converter.sv - self-checking bench for int_to_fp32_converter
module tb_int_to_fp32_converter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        in_signed;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        out_inexact;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    int_to_fp32_converter #(.XLEN(32), .EXP_BIAS(127)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .in_signed   (in_signed),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_inexact (out_inexact)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: exact integer value rounded to 24 significant bits, nearest-even.
    // lat = edges after the accepting edge until out_valid is seen.
    function automatic void model(input logic [31:0] d, input logic s,
                                  output logic [31:0] r, output logic x, output int lat);
        logic            neg;
        longint unsigned m, q, rem, half;
        int              msb, sh, e;
        neg = s && d[31];
        m   = neg ? (64'h1_0000_0000 - longint'(d)) : longint'(d);
        r   = 32'h0;
        x   = 1'b0;
        lat = 0;
        if (m == 0) return;
        msb = 0;
        for (int i = 0; i < 32; i++)
            if (((m >> i) & 64'd1) == 64'd1) msb = i;
        e   = msb;
        rem = 0;
        if (msb <= 23) begin
            q = m << (23 - msb);
        end else begin
            sh   = msb - 23;
            q    = m >> sh;
            rem  = m - (q << sh);
            half = 64'd1 << (sh - 1);
            if (rem > half || (rem == half && q[0])) q = q + 1;
            if (q == (64'd1 << 24)) begin
                q = q >> 1;
                e = e + 1;
            end
        end
        r   = {neg, 8'(e + 127), q[22:0]};
        x   = (rem != 0);
        lat = (31 - msb) + 2;
    endfunction

    task automatic do_conv(input logic [31:0] d, input logic s, input string tag, input int bp);
        logic [31:0] er;
        logic        ex;
        int          elat;
        int          lat;
        model(d, s, er, ex, elat);
        @(negedge clk);
        in_data   = d;
        in_signed = s;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        chk({tag, " in_ready_idle"}, {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk({tag, " latency"}, 32'(lat), 32'(elat));
        chk({tag, " data"}, out_data, er);
        chk({tag, " inexact"}, {31'd0, out_inexact}, {31'd0, ex});
        for (int i = 0; i < bp; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = 32'h1234_5678;
            @(posedge clk);
            #1;
            chk({tag, " bp_valid"}, {31'd0, out_valid}, 32'd1);
            chk({tag, " bp_data"}, out_data, er);
            chk({tag, " bp_in_ready"}, {31'd0, in_ready}, 32'd0);
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk({tag, " release_valid"}, {31'd0, out_valid}, 32'd0);
        chk({tag, " release_in_ready"}, {31'd0, in_ready}, 32'd1);
        if (bp > 0) begin
            @(posedge clk);
            #1;
            chk({tag, " no_stray_accept"}, {31'd0, out_valid}, 32'd0);
            chk({tag, " still_idle"}, {31'd0, in_ready}, 32'd1);
        end
    endtask

    initial begin
        logic [31:0] rd;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = 32'h0;
        in_signed = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset in_ready", {31'd0, in_ready}, 32'd1);
        chk("reset out_valid", {31'd0, out_valid}, 32'd0);
        chk("reset out_data", out_data, 32'h0);
        chk("reset out_inexact", {31'd0, out_inexact}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        do_conv(32'h0000_0001, 1'b0, "u_one", 0);
        do_conv(32'hFFFF_FFFF, 1'b1, "s_minus_one", 0);
        do_conv(32'h8000_0000, 1'b1, "s_min", 0);
        do_conv(32'h8000_0000, 1'b0, "u_msb", 0);
        do_conv(32'h0000_0000, 1'b1, "s_zero", 0);
        do_conv(32'h0000_0000, 1'b0, "u_zero", 0);
        do_conv(32'hFFFF_FFFF, 1'b0, "u_max_carry", 0);
        do_conv(32'h0100_0001, 1'b0, "tie_even", 0);
        do_conv(32'h0100_0003, 1'b0, "tie_odd", 0);
        do_conv(32'h0100_0005, 1'b0, "guard_lsb0", 0);
        do_conv(32'h0100_0003, 1'b0, "backpressure", 5);

        chk("const u_one", 32'h3F80_0000, {1'b0, 8'd127, 23'd0} | out_data & 32'h0);
        chk("const tie_odd", out_data, 32'h4B80_0002);

        // Asynchronous reset in the middle of normalisation.
        @(negedge clk);
        in_data   = 32'h0000_0001;
        in_signed = 1'b0;
        in_valid  = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst out_valid", {31'd0, out_valid}, 32'd0);
        chk("async_rst in_ready", {31'd0, in_ready}, 32'd1);
        chk("async_rst out_data", out_data, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        do_conv(32'h0000_0002, 1'b0, "after_rst", 0);

        for (int n = 0; n < 40; n++) begin
            rd = $urandom() >> $urandom_range(0, 31);
            do_conv(rd, 1'($urandom_range(0, 1)), "random", 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
